frame_row_scanout: RTL and testbench



---
 rtl/frame_row_scanout.sv | 188 ++++++++++++++++++
 tb/tb_frame_row_scanout.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_row_scanout.sv
// Row buffer scanout: fetches packed 32-bit words from the row buffer
// and emits one 8-bit pixel per cycle with horizontal repetition.
module frame_row_scanout #(
  parameter int WORDS      = 80,
  parameter int PIX_REPEAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        line_start,
  output logic [9:0]  raddr,
  output logic        renable,
  input  logic [31:0] rdata,
  output logic [7:0]  pixel,
  output logic        pixel_valid,
  output logic        row_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    STREAM
  } state_t;

  localparam logic [9:0] LAST_W = 10'(WORDS - 1);
  localparam logic [1:0] LAST_R = 2'(PIX_REPEAT - 1);

  state_t      r_state;
  logic [9:0]  r_word;
  logic [1:0]  r_pix;
  logic [1:0]  r_rep;
  logic [31:0] r_cur;
  logic [31:0] r_nxt;
  logic        r_ren_d;
  logic [9:0]  r_raddr;
  logic        r_ren;
  logic [7:0]  r_pixel;
  logic        r_valid;
  logic        r_done;
  logic        r_busy;

  state_t      w_state;
  logic [9:0]  w_word;
  logic [1:0]  w_pix;
  logic [1:0]  w_rep;
  logic [31:0] w_cur;
  logic [9:0]  w_raddr;
  logic        w_ren;
  logic [7:0]  w_pixel;
  logic        w_valid;
  logic        w_done;
  logic        w_busy;
  logic [9:0]  w_word_inc;
  logic [1:0]  w_pix_inc;

  assign w_word_inc = r_word + 10'd1;
  assign w_pix_inc  = r_pix + 2'd1;

  function automatic logic [7:0] f_byte(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    f_byte = w[{i, 3'b000} +: 8];
  endfunction

  // Counters describe the pixel currently on the registered outputs
  always_comb begin
    w_state = r_state;
    w_word  = r_word;
    w_pix   = r_pix;
    w_rep   = r_rep;
    w_cur   = r_cur;
    w_raddr = r_raddr;
    w_ren   = 1'b0;
    w_pixel = 8'd0;
    w_valid = 1'b0;
    w_done  = 1'b0;
    w_busy  = r_busy;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
      end
      FETCH: begin
        w_state = WAIT;
      end
      WAIT: begin
        w_state = STREAM;
        w_cur   = rdata;
        w_pixel = rdata[7:0];
        w_valid = 1'b1;
        w_word  = 10'd0;
        w_pix   = 2'd0;
        w_rep   = 2'd0;
        if (LAST_W != 10'd0) begin
          w_ren   = 1'b1;
          w_raddr = 10'd1;
        end
      end
      STREAM: begin
        w_valid = 1'b1;
        if (r_rep != LAST_R) begin
          w_rep   = r_rep + 2'd1;
          w_pixel = f_byte(r_cur, r_pix);
        end else begin
          w_rep = 2'd0;
          if (r_pix != 2'd3) begin
            w_pix   = w_pix_inc;
            w_pixel = f_byte(r_cur, w_pix_inc);
          end else if (r_word != LAST_W) begin
            w_pix   = 2'd0;
            w_word  = w_word_inc;
            w_cur   = r_nxt;
            w_pixel = r_nxt[7:0];
            if (w_word_inc != LAST_W) begin
              w_ren   = 1'b1;
              w_raddr = r_word + 10'd2;
            end
          end else begin
            w_state = IDLE;
            w_valid = 1'b0;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_pix   = 2'd0;
            w_word  = 10'd0;
          end
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    // A new row always wins; row_done of a finishing row is kept
    if (line_start) begin
      w_state = FETCH;
      w_raddr = 10'd0;
      w_ren   = 1'b1;
      w_busy  = 1'b1;
      w_valid = 1'b0;
      w_pixel = 8'd0;
      w_word  = 10'd0;
      w_pix   = 2'd0;
      w_rep   = 2'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_word  <= 10'd0;
      r_pix   <= 2'd0;
      r_rep   <= 2'd0;
      r_cur   <= 32'd0;
      r_nxt   <= 32'd0;
      r_ren_d <= 1'b0;
      r_raddr <= 10'd0;
      r_ren   <= 1'b0;
      r_pixel <= 8'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_word  <= w_word;
      r_pix   <= w_pix;
      r_rep   <= w_rep;
      r_cur   <= w_cur;
      r_ren_d <= r_ren;
      if (r_ren_d) begin
        r_nxt <= rdata;
      end
      r_raddr <= w_raddr;
      r_ren   <= w_ren;
      r_pixel <= w_pixel;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  assign raddr       = r_raddr;
  assign renable     = r_ren;
  assign pixel       = r_pixel;
  assign pixel_valid = r_valid;
  assign row_done    = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_frame_row_scanout.sv
// Bench for frame_row_scanout: random rows, aborts, async reset,
// scoreboarded pixel stream and read-port discipline.
module tb_frame_row_scanout;

  localparam int W  = 80;
  localparam int PR = 2;
  localparam int RL = W * 4 * PR;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  raddr;
  logic        renable;
  logic [31:0] rdata = 32'd0;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        row_done;
  logic        busy;

  frame_row_scanout #(
    .WORDS(W),
    .PIX_REPEAT(PR)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .line_start(line_start),
    .raddr(raddr),
    .renable(renable),
    .rdata(rdata),
    .pixel(pixel),
    .pixel_valid(pixel_valid),
    .row_done(row_done),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] mem [W];
  always @(posedge clock) begin
    if (renable) rdata <= mem[int'(raddr) % W];
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q [$];
  int         done_q [$];

  int rd_idx = 0;
  int saved_rd = 0;
  int ls_cyc = -100;
  int last_ra = 0;
  int run = 0;
  int last_run = 0;
  bit prev_valid = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: word k = {4{k}} + 03020100, mode 1: random contents
  task automatic issue_row(input int mode, output int s);
    for (int k = 0; k < W; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      if (mode == 0) mem[k] = {4{kb}} + 32'h03020100;
      else mem[k] = $urandom;
    end
    line_start = 1'b1;
    s = cyc;
    tick();
    line_start = 1'b0;
    if (exp_q.size() != 0 && done_q.size() != 0) void'(done_q.pop_back());
    exp_q.delete();
    for (int k = 0; k < W; k++)
      for (int b = 0; b < 4; b++)
        for (int r = 0; r < PR; r++)
          exp_q.push_back(8'((mem[k] >> (8 * b)) & 32'hFF));
    done_q.push_back(s + RL + 3);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(done_q.size() == 0, "row_done_timeout", done_q.size(), 0);
  endtask

  always @(negedge clock) begin
    int reads;
    int d;
    logic [7:0] e;
    if (renable) begin
      chk(int'(raddr) == rd_idx && int'(raddr) < W, "read_addr",
          raddr, rd_idx);
      rd_idx++;
    end else begin
      chk(int'(raddr) == last_ra, "raddr_hold", raddr, last_ra);
    end
    last_ra = int'(raddr);
    reads = (ls_cyc == cyc - 1) ? saved_rd : rd_idx;
    if (line_start) begin
      saved_rd = rd_idx;
      rd_idx = 0;
      ls_cyc = cyc;
    end
    if (pixel_valid) begin
      chk(busy == 1'b1, "busy_in_row", busy, 1);
      if (!prev_valid)
        chk(cyc == ls_cyc + 3, "first_pixel_cycle", cyc, ls_cyc + 3);
      if (exp_q.size() == 0) begin
        chk(1'b0, "extra_pixel", pixel, 0);
      end else begin
        e = exp_q.pop_front();
        chk(pixel == e, "pixel", pixel, e);
      end
      run++;
    end else begin
      chk(pixel == 8'd0, "pixel_idle_zero", pixel, 0);
      if (prev_valid) last_run = run;
      run = 0;
    end
    if (row_done) begin
      chk(reads == W, "reads_per_row", reads, W);
      chk(last_run == RL && prev_valid, "row_length", last_run, RL);
      if (done_q.size() == 0) begin
        chk(1'b0, "unexpected_row_done", cyc, 0);
      end else begin
        d = done_q.pop_front();
        chk(cyc == d, "row_done_cycle", cyc, d);
      end
      if (ls_cyc != cyc - 1) chk(busy == 1'b0, "busy_after_done", busy, 0);
    end
    prev_valid = pixel_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d: got 0 expected 1", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s2;
    #1;
    chk(raddr == 10'd0 && renable == 1'b0, "reset_read_port", raddr, 0);
    chk(pixel == 8'd0 && pixel_valid == 1'b0, "reset_pixel", pixel, 0);
    chk(row_done == 1'b0 && busy == 1'b0, "reset_flags", busy, 0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();

    issue_row(0, s);
    wait_done(RL + 50);
    repeat ($urandom_range(1, 10)) tick();

    // line_start lands on the final pixel cycle of the first row
    issue_row(1, s);
    repeat (RL + 1) tick();
    issue_row(1, s2);
    wait_done(RL + 50);
    repeat ($urandom_range(1, 10)) tick();

    issue_row(1, s);
    repeat (99) tick();
    issue_row(1, s2);
    chk(renable == 1'b1, "abort_renable", renable, 1);
    chk(raddr == 10'd0, "abort_raddr", raddr, 0);
    chk(pixel_valid == 1'b0, "abort_gap1", pixel_valid, 0);
    chk(row_done == 1'b0, "abort_no_done", row_done, 0);
    tick();
    chk(pixel_valid == 1'b0, "abort_gap2", pixel_valid, 0);
    wait_done(RL + 50);

    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      issue_row(1, s);
      repeat ($urandom_range(0, RL)) tick();
      issue_row(1, s2);
      wait_done(RL + 50);
    end

    issue_row(1, s);
    repeat (200) tick();
    #2;
    reset_n = 1'b0;
    last_ra = 0;
    #1;
    chk(raddr == 10'd0, "async_rst_raddr", raddr, 0);
    chk(renable == 1'b0, "async_rst_renable", renable, 0);
    chk(pixel == 8'd0, "async_rst_pixel", pixel, 0);
    chk(pixel_valid == 1'b0, "async_rst_valid", pixel_valid, 0);
    chk(row_done == 1'b0, "async_rst_done", row_done, 0);
    chk(busy == 1'b0, "async_rst_busy", busy, 0);
    exp_q.delete();
    done_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk(pixel_valid == 1'b0 && busy == 1'b0 && renable == 1'b0,
          "idle_after_reset", {pixel_valid, busy, renable}, 0);
    end

    issue_row(1, s);
    wait_done(RL + 50);
    repeat (5) tick();
    chk(exp_q.size() == 0, "pixels_left", exp_q.size(), 0);
    chk(done_q.size() == 0, "done_left", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
